// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encoding, BCD score
// widths and a BCD-to-binary helper used by the win and winner comparators.
package pong_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PLAY    = 3'd1;
    localparam logic [2:0] NEWBALL = 3'd2;
    localparam logic [2:0] PAUSE   = 3'd3;
    localparam logic [2:0] OVER    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = IDLE,
        ST_PLAY    = PLAY,
        ST_NEWBALL = NEWBALL,
        ST_PAUSE   = PAUSE,
        ST_OVER    = OVER
    } state_e;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SCORE_W = 2 * BCD_W;
    localparam int unsigned TIMER_W = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'h99;

    // Two-digit BCD to binary (0..99).
    function automatic logic [6:0] bcd_to_bin(input logic [SCORE_W-1:0] v);
        return 7'(v[SCORE_W-1:BCD_W]) * 7'd10 + 7'(v[BCD_W-1:0]);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Controller-facing bundle of the pong game controller.
// slave : controller side (takes pulses/buttons, drives state and scores).
// master: environment side (graphics unit, buttons, text/rgb mux).
interface pong_game_ctrl_if
    import pong_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2
);
    logic                             frame_tick;
    logic                             start;
    logic                             pause_req;
    logic [NUM_PLAYERS-1:0]           hit;
    logic [NUM_PLAYERS-1:0]           miss;
    logic [2:0]                       state;
    logic                             gra_still;
    logic [3:0]                       balls_left;
    logic [SCORE_W*NUM_PLAYERS-1:0]   scores;
    logic [1:0]                       serve_id;
    logic                             winner_valid;
    logic [1:0]                       winner_id;

    modport master (
        output frame_tick, start, pause_req, hit, miss,
        input  state, gra_still, balls_left, scores, serve_id, winner_valid, winner_id
    );

    modport slave (
        input  frame_tick, start, pause_req, hit, miss,
        output state, gra_still, balls_left, scores, serve_id, winner_valid, winner_id
    );
endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter, saturating at 99.
// Ports: clk, reset (async, active-high), inc (add one), clr (clear, wins over
// inc), q (registered score), q_next_c (combinational value q takes next edge).
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [SCORE_W-1:0] q,
    output logic [SCORE_W-1:0] q_next_c
);

    // Next score; ones digit wraps 9->0 with carry into tens.
    always_comb begin
        q_next_c = q;
        if (clr) begin
            q_next_c = '0;
        end else if (inc && (q != SCORE_MAX)) begin
            if (q[BCD_W-1:0] == 4'd9) begin
                q_next_c = {q[SCORE_W-1:BCD_W] + 4'd1, 4'd0};
            end else begin
                q_next_c = {q[SCORE_W-1:BCD_W], q[BCD_W-1:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_next_c;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-control FSMD: IDLE/PLAY/NEWBALL/PAUSE/OVER, wait timer, per-player
// BCD scores, serve tracking and winner reporting.
// Ports: clk, reset (async, active-high), bus (pong_game_ctrl_if.slave):
//   in : frame_tick, start, pause_req, hit[N], miss[N]
//   out: state, gra_still, balls_left, scores, serve_id, winner_valid, winner_id
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned BALLS       = 3,
    parameter int unsigned WIN_SCORE   = 0,
    parameter int unsigned WAIT_FRAMES = 120,
    parameter int unsigned PAUSE_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    pong_game_ctrl_if.slave   bus
);

    state_e               state_q;
    logic                 gra_q;
    logic [3:0]           balls_q;
    logic [1:0]           serve_q;
    logic                 wv_q;
    logic [1:0]           wid_q;
    logic [TIMER_W-1:0]   timer_q;

    logic [NUM_PLAYERS-1:0] inc_c;
    logic                   clr_c;
    logic [SCORE_W-1:0]     score_q     [NUM_PLAYERS];
    logic [SCORE_W-1:0]     score_nxt_c [NUM_PLAYERS];

    logic                   win_c;
    logic [1:0]             win_id_c;
    logic                   miss_any_c;
    logic [1:0]             miss_id_c;
    logic [6:0]             max_c;
    logic [1:0]             max_id_c;
    logic [2:0]             max_cnt_c;

    // Hits only count in PLAY; scores clear in IDLE and on the OVER->IDLE edge.
    assign inc_c = (state_q == ST_PLAY) ? bus.hit : '0;
    assign clr_c = (state_q == ST_IDLE) || ((state_q == ST_OVER) && (timer_q == '0));

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
        bcd_score_counter u_score (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc_c[g]),
            .clr      (clr_c),
            .q        (score_q[g]),
            .q_next_c (score_nxt_c[g])
        );
        assign bus.scores[SCORE_W*g +: SCORE_W] = score_q[g];
    end

    // Win, miss and winner comparators on post-increment scores; lowest index wins ties.
    always_comb begin
        win_c      = 1'b0;
        win_id_c   = 2'd0;
        miss_any_c = |bus.miss;
        miss_id_c  = 2'd0;
        max_c      = 7'd0;
        max_id_c   = 2'd0;
        max_cnt_c  = 3'd0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if ((WIN_SCORE != 0) && (bcd_to_bin(score_nxt_c[i]) == 7'(WIN_SCORE))) begin
                win_c    = 1'b1;
                win_id_c = 2'(i);
            end
            if (bus.miss[i]) begin
                miss_id_c = 2'(i);
            end
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bcd_to_bin(score_nxt_c[i]) > max_c) begin
                max_c     = bcd_to_bin(score_nxt_c[i]);
                max_id_c  = 2'(i);
                max_cnt_c = 3'd1;
            end else if (bcd_to_bin(score_nxt_c[i]) == max_c) begin
                max_cnt_c = max_cnt_c + 3'd1;
            end
        end
    end

    // Game FSM with timer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gra_q   <= 1'b1;
            balls_q <= 4'(BALLS);
            serve_q <= 2'd0;
            wv_q    <= 1'b0;
            wid_q   <= 2'd0;
            timer_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_PLAY;
                        gra_q   <= 1'b0;
                        balls_q <= 4'(BALLS - 1);
                        serve_q <= 2'd0;
                    end
                end
                ST_PLAY: begin
                    if (win_c) begin
                        state_q <= ST_OVER;
                        gra_q   <= 1'b1;
                        wv_q    <= 1'b1;
                        wid_q   <= win_id_c;
                        timer_q <= TIMER_W'(WAIT_FRAMES);
                    end else if (miss_any_c) begin
                        gra_q   <= 1'b1;
                        serve_q <= miss_id_c;
                        timer_q <= TIMER_W'(WAIT_FRAMES);
                        if (balls_q == 4'd0) begin
                            state_q <= ST_OVER;
                            wv_q    <= (max_cnt_c == 3'd1);
                            wid_q   <= (max_cnt_c == 3'd1) ? max_id_c : 2'd0;
                        end else begin
                            state_q <= ST_NEWBALL;
                            balls_q <= balls_q - 4'd1;
                        end
                    end else if ((PAUSE_EN != 0) && bus.pause_req) begin
                        state_q <= ST_PAUSE;
                        gra_q   <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.pause_req) begin
                        state_q <= ST_PLAY;
                        gra_q   <= 1'b0;
                    end
                end
                ST_NEWBALL: begin
                    if (timer_q == '0) begin
                        if (bus.start) begin
                            state_q <= ST_PLAY;
                            gra_q   <= 1'b0;
                        end
                    end else if (bus.frame_tick) begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                ST_OVER: begin
                    if (timer_q == '0) begin
                        state_q <= ST_IDLE;
                        balls_q <= 4'(BALLS);
                        wv_q    <= 1'b0;
                        wid_q   <= 2'd0;
                    end else if (bus.frame_tick) begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gra_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.gra_still    = gra_q;
    assign bus.balls_left   = balls_q;
    assign bus.serve_id     = serve_q;
    assign bus.winner_valid = wv_q;
    assign bus.winner_id    = wid_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Parametrised game-control FSMD for the pong design, sitting between the graphics unit (hit/miss pulses) and the text/rgb mux (state, scores, balls). It generalises the two-player newgame/play/newball/over controller to NUM_PLAYERS players, adds a pause state, an optional win-score, serve tracking and winner reporting, and absorbs the 2-second wait timer and the per-player BCD score counters.

## Interface
- NUM_PLAYERS, 2, number of players/paddles; legal range 2..4.
- BALLS, 3, balls per game; legal range 1..15.
- WIN_SCORE, 0, BCD-integer score that ends the game immediately; 0 disables; legal range 0..99.
- WAIT_FRAMES, 120, frame_tick count for the newball/over wait; legal range 1..255.
- PAUSE_EN, 1, 1 enables the PAUSE state; 0 ignores pause_req.

- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- frame_tick  in  1  one-clk pulse per frame (x==0 && y==0).
- start  in  1  level; OR of player buttons.
- pause_req  in  1  one-clk pulse.
- hit  in  NUM_PLAYERS  one-clk pulse per player: ball returned.
- miss  in  NUM_PLAYERS  one-clk pulse per player: ball lost.
- state  out  3  current state encoding.
- gra_still  out  1  1 = freeze graphics.
- balls_left  out  4  balls remaining after the one in play.
- scores  out  8*NUM_PLAYERS  two BCD digits per player; player i at [8i+7:8i], tens in the upper nibble.
- serve_id  out  2  player who serves next ball.
- winner_valid  out  1  winner_id meaningful (OVER only).
- winner_id  out  2  winning player.

## Operation
- States: IDLE, PLAY, NEWBALL, PAUSE, OVER.
- IDLE: gra_still=1; scores held clear; balls_left=BALLS; on start=1 -> PLAY, balls_left=BALLS-1, serve_id=0.
- PLAY: gra_still=0. hit[i] increments score i; simultaneous hits from several players each increment. Scores saturate at 99.
- Win check: WIN_SCORE!=0 and any score equals WIN_SCORE after the increment -> OVER. winner_id is the lowest such index; the wait timer loads.
- Miss: any miss bit -> OVER if balls_left==0, else NEWBALL with balls_left-1. serve_id is set to the lowest missing index and the timer loads WAIT_FRAMES.
- Same-cycle priority: hits are always counted, then win beats miss, then miss beats pause_req.
- pause_req in PLAY with PAUSE_EN=1 -> PAUSE: gra_still=1; hit/miss ignored. pause_req in PAUSE -> PLAY. Other states ignore pause_req.
- NEWBALL: the timer decrements on frame_tick. When timer==0 and start=1 -> PLAY. A start held during the wait is accepted at the cycle the timer reaches 0.
- OVER: gra_still=1. Timer runs; timer==0 -> IDLE, which clears scores.
- winner_valid in OVER:
  - Win-score exit: 1.
  - Ball-exhaustion exit: 1 iff a unique maximum score exists; winner_id is that player. A tie gives 0.
  - Outside OVER: winner_valid=0.

## Timing
- All outputs are registered. The state and score change is visible on the clk edge after the input pulse (latency 1).
- Timer is 8 bits. It loads on the transition edge, then counts exactly WAIT_FRAMES frame_ticks to 0. A frame_tick coincident with the load edge is not counted.
- Reset values: state=IDLE, gra_still=1, balls_left=BALLS, scores=0, serve_id=0, winner_valid=0, winner_id=0, timer=0.
- Reset mid-game aborts immediately to the reset values; no pending pulses survive.
- hit/miss/pause_req are single-cycle and never held; a pulse in a state that ignores it is dropped.

## Structure
- Package pong_pkg holds:
  - the state encoding localparams: IDLE=0, PLAY=1, NEWBALL=2, PAUSE=3, OVER=4;
  - the BCD digit width;
  - a function converting a 2-digit BCD value to binary, used for win and max comparison.
- Sub-module bcd_score_counter: 2-digit BCD with inc, clr and saturate at 99, instanced NUM_PLAYERS times via generate.
- The FSM, timer and winner comparator live in pong_game_ctrl.

## Test plan
- Reset, then start=1 -> state=PLAY and balls_left=2 one clk later, with gra_still=0.
- Defaults, hit[0] pulsed 12 times -> scores[7:0]=8'h12. 100 hits -> stays 8'h99.
- NUM_PLAYERS=3, miss=3'b110 in PLAY -> NEWBALL with serve_id=1. start held -> PLAY exactly after the 120th frame_tick, not before.
- BALLS=1, scores 5/5, miss[1] -> OVER with winner_valid=0. After 120 frame_ticks -> IDLE with scores=0.
- WIN_SCORE=3, player1 at 2, same-cycle hit[1] and miss[0] -> OVER with winner_valid=1 and winner_id=1; balls_left unchanged.
- pause_req in PLAY -> PAUSE and hit ignored. Second pause_req -> PLAY. Reset asserted in PAUSE -> reset values asynchronously.
